// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: UART transmitter with baud-tick generator, transmit FIFO and configurable framing
module uart_tx_fifo_cfg #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [DATA_BITS-1:0]             wr_data,
    output logic                             full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             tx,
    output logic                             tx_busy,
    output logic                             tx_done
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE * 2);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        wp_q, rp_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic                 push, pop, tick, bit_end, stop_end;
    logic [DATA_BITS-1:0] head;

    // a write while full is dropped even if a pop frees a slot in the same cycle
    assign push     = wr_en && !full;
    assign tick     = div_q == DW'(DIV - 1);
    assign bit_end  = tick && tick_q == TW'(OVERSAMPLE - 1);
    assign stop_end = tick && tick_q == TW'(STOP_BITS * OVERSAMPLE - 1);
    assign head     = mem[rp_q];
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
    // divider restarts with every frame so each bit is exactly OVERSAMPLE*DIV clocks
    assign div_d    = (pop || tick) ? '0 : div_q + DW'(1);

    // state, counters and FIFO pointers; async reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            if (push) wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= wr_data;
    end

    // walk START/DATA/PAR/STOP on baud ticks; pop the FIFO in IDLE or at the last stop tick
    always_comb begin
        state_d = state_q;
        tick_d  = (state_q != IDLE && tick) ? tick_q + TW'(1) : tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: pop = cnt_q != '0;
            START: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_d = '0;
                    sh_d   = sh_q >> 1;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = PARITY != 0 ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tick_d  = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (stop_end) begin
                    tick_d  = '0;
                    done_d  = 1'b1;
                    pop     = cnt_q != '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            sh_d    = head;
            par_d   = (^head) ^ (PARITY == 1);
        end
    end

    // line level from the current state; idle and stop are high
    always_comb begin
        tx = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PAR ? par_q : 1'b1;
    end

    assign tx_busy    = state_q != IDLE;
    assign tx_done    = done_q;
    assign full       = cnt_q == CW'(FIFO_DEPTH);
    assign fifo_count = cnt_q;
endmodule
